// File: rtl/jt5205_decim2x.sv
// 2:1 half-band decimator for 12-bit signed PCM.
// Serial shift-add datapath, one output every second input sample.
module jt5205_decim2x (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [11:0] din,
  output logic [11:0] dout,
  output logic        dout_cen
);

  typedef enum logic [2:0] {
    IDLE,
    S1,
    S2,
    S3,
    S4
  } state_t;

  state_t st;

  logic signed [11:0] x [0:6];
  logic               phase;
  logic               trigger;

  logic signed [12:0] po;
  logic signed [12:0] pm;
  logic signed [11:0] pc;
  logic signed [17:0] acc;

  logic signed [17:0] po18;
  logic signed [17:0] pm18;
  logic signed [17:0] pc18;
  logic signed [17:0] rnd;
  logic signed [17:0] r;
  logic        [11:0] sat;

  assign trigger = cen & phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) x[i] <= '0;
      phase <= 1'b0;
    end else if (cen) begin
      x[0] <= din;
      for (int i = 1; i < 7; i++) x[i] <= x[i-1];
      phase <= ~phase;
    end
  end

  assign po18 = {{5{po[12]}}, po};
  assign pm18 = {{5{pm[12]}}, pm};
  assign pc18 = {{6{pc[11]}}, pc};
  assign rnd  = acc + 18'sd16;
  assign r    = rnd >>> 5;

  // Clamp the rounded sum into the 12-bit output range
  always_comb begin
    sat = r[11:0];
    if (r > 18'sd2047)
      sat = 12'h7ff;
    else if (r < -18'sd2048)
      sat = 12'h800;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      po       <= '0;
      pm       <= '0;
      pc       <= '0;
      acc      <= '0;
      dout     <= '0;
      dout_cen <= 1'b0;
    end else begin
      dout_cen <= 1'b0;
      case (st)
        IDLE: begin
          if (trigger) st <= S1;
        end
        S1: begin
          po <= {x[0][11], x[0]} + {x[6][11], x[6]};
          pm <= {x[2][11], x[2]} + {x[4][11], x[4]};
          pc <= x[3];
          st <= S2;
        end
        S2: begin
          acc <= (pm18 <<< 3) + pm18 - po18;
          st  <= S3;
        end
        S3: begin
          acc <= acc + (pc18 <<< 4);
          st  <= S4;
        end
        S4: begin
          dout     <= sat;
          dout_cen <= 1'b1;
          st       <= trigger ? S1 : IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
